// File: rtl/ring_lock_fsm.sv
// ring_lock_fsm: key-locked ring of KEY_W stages with decoy diversion and sticky output corruption
module ring_lock_fsm #(
   parameter int                 KEY_W         = 4,
   parameter int                 OUT_W         = 9,
   parameter logic [KEY_W-1:0]   CORRECT_KEY   = 4'b1011,
   parameter logic [OUT_W-1:0]   PAT           = 9'h007,
   parameter logic [OUT_W-1:0]   CORRUPT_MASK  = 9'h1FF,
   parameter int                 CORRUPT_AFTER = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       x,
   input  logic [KEY_W-1:0] key,
   output logic [OUT_W-1:0] y
);
   localparam int SW = $clog2(KEY_W);
   localparam int CW = $clog2(CORRUPT_AFTER + 1);
   localparam logic [SW-1:0] LAST = SW'(KEY_W - 1);
   localparam logic [CW-1:0] CMAX = CW'(CORRUPT_AFTER);
   localparam logic [0:0] RUN = 1'b0, DECOY = 1'b1;

   logic [0:0]       st, st_n;
   logic [SW-1:0]    stage, stage_n, fwd, rev;
   logic [CW-1:0]    cnt, cnt_n;
   logic [OUT_W-1:0] y_n;
   logic             adv, wrong;

   function automatic logic [OUT_W-1:0] rotl(input logic [SW-1:0] s);
      rotl = (PAT << s) | (PAT >> (OUT_W - int'(s)));
   endfunction

   // while in decoy, stage holds the recorded target so y mimics a correct advance
   always_comb begin
      fwd     = (stage == LAST) ? '0 : stage + SW'(1);
      rev     = (stage == '0) ? LAST : stage - SW'(1);
      adv     = x[0] && !x[2];
      wrong   = (st == RUN) && adv && x[1] && (key[stage] != CORRECT_KEY[stage]);
      st_n    = wrong ? DECOY : RUN;
      stage_n = (st == DECOY) ? '0 : !adv ? stage : !x[1] ? rev : fwd;
      cnt_n   = (wrong && cnt != CMAX) ? cnt + CW'(1) : cnt;
      y_n     = rotl(stage_n) ^ ((cnt_n == CMAX) ? CORRUPT_MASK : '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st    <= RUN;
         stage <= '0;
         cnt   <= '0;
         y     <= PAT;
      end else begin
         st    <= st_n;
         stage <= stage_n;
         cnt   <= cnt_n;
         y     <= y_n;
      end
   end
endmodule

// File: tb/tb_ring_lock_fsm.sv
// tb_ring_lock_fsm: directed checks of ring advance, decoy, corruption, hold/reverse and reset
module tb_ring_lock_fsm;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] x   = 3'b000;
   logic [3:0] key = 4'b0000;
   logic [8:0] y;
   int total = 0;
   int bad   = 0;

   ring_lock_fsm dut (.clk(clk), .rst(rst), .x(x), .key(key), .y(y));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: y=%03h expected %03h", tag, got, exp);
      end
   endtask

   // apply inputs, clock once, compare y just after the edge
   task automatic step(input logic r, input logic [2:0] xv, input logic [3:0] kv,
                       input logic [8:0] exp, input string tag);
      rst = r;
      x   = xv;
      key = kv;
      @(posedge clk);
      #1;
      chk(tag, y, exp);
   endtask

   initial begin
      @(posedge clk); #1;
      step(1, 3'b011, 4'b1011, 9'h007, "reset");
      // correct ring with wrap-around
      step(0, 3'b011, 4'b1011, 9'h00E, "ring1");
      step(0, 3'b011, 4'b1011, 9'h01C, "ring2");
      step(0, 3'b011, 4'b1011, 9'h038, "ring3");
      step(0, 3'b011, 4'b1011, 9'h007, "ring_wrap");
      // four wrong-bit decoys below threshold; decoy ignores x (hold included)
      for (int i = 0; i < 4; i++) begin
         step(0, 3'b011, 4'b1111, 9'h00E, "wb_s1");
         step(0, 3'b011, 4'b1111, 9'h01C, "wb_s2");
         step(0, 3'b011, 4'b1111, 9'h038, "wb_decoy");
         step(0, (i == 0) ? 3'b111 : 3'b011, 4'b1111, 9'h007, "wb_return");
      end
      // fifth decoy entry triggers corruption
      step(0, 3'b011, 4'b1111, 9'h00E, "c_s1");
      step(0, 3'b011, 4'b1111, 9'h01C, "c_s2");
      step(0, 3'b011, 4'b1111, 9'h1C7, "c_decoy");
      step(0, 3'b011, 4'b1111, 9'h1F8, "c_return");
      step(0, 3'b011, 4'b1011, 9'h1F1, "c_adv1");
      step(0, 3'b011, 4'b1011, 9'h1E3, "c_adv2");
      step(0, 3'b011, 4'b1011, 9'h1C7, "c_adv3");
      step(0, 3'b011, 4'b1011, 9'h1F8, "c_adv_wrap");
      step(1, 3'b011, 4'b1011, 9'h007, "c_reset");
      step(0, 3'b011, 4'b1011, 9'h00E, "post_reset_adv");
      // hold then ungated reverse
      step(0, 3'b111, 4'b0000, 9'h00E, "hold1");
      step(0, 3'b111, 4'b0000, 9'h00E, "hold2");
      step(0, 3'b111, 4'b0000, 9'h00E, "hold3");
      step(0, 3'b000, 4'b0000, 9'h00E, "nogo");
      step(0, 3'b001, 4'b0000, 9'h007, "rev_to0");
      step(0, 3'b001, 4'b0000, 9'h038, "rev_wrap");
      step(0, 3'b001, 4'b0000, 9'h01C, "rev_to2");
      // reset while in decoy, then one decoy must not corrupt
      step(0, 3'b011, 4'b1111, 9'h038, "md_decoy");
      step(1, 3'b011, 4'b1111, 9'h007, "md_reset");
      step(0, 3'b011, 4'b1111, 9'h00E, "md_s1");
      step(0, 3'b011, 4'b1111, 9'h01C, "md_s2");
      step(0, 3'b011, 4'b1111, 9'h038, "md_decoy2");
      step(0, 3'b011, 4'b1111, 9'h007, "md_return");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ring_lock_fsm.md
# ring_lock_fsm

Parametrised key-locked finite-state controller for the locking benchmark set. It generalises the single-key, single-decoy locked FSM to KEY_W key-gated transitions around a ring of KEY_W functional stages. Each wrong key bit diverts the machine into a decoy state that mimics the correct output for one cycle. After CORRUPT_AFTER decoy entries, a sticky corruption mask is applied to all outputs. It sits alongside the other locked FSM benchmarks as a scalable stimulus for attack and evaluation flows.

## Interface
- KEY_W, 4, number of ring stages and key bits; must be at least 2.
- OUT_W, 9, output width; must be at least KEY_W.
- CORRECT_KEY, 4'b1011, correct key; bit i gates the forward advance out of stage i.
- PAT, 9'h007, output pattern of stage 0; stage i outputs PAT rotated left by i within OUT_W.
- CORRUPT_MASK, 9'h1FF, XOR mask applied to y once corruption is set.
- CORRUPT_AFTER, 5, decoy-entry count that sets corruption; must be at least 1.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- x  in  3  x[0]=go, x[1]=dir (1 = forward), x[2]=hold.
- key  in  KEY_W  applied key.
- y  out  OUT_W  registered output.

## Operation
Internal state:
- stage index 0..KEY_W-1.
- decoy flag, plus the recorded decoy target.
- counter cnt, $clog2(CORRUPT_AFTER+1) bits, saturating at CORRUPT_AFTER.
- corrupt, true when cnt == CORRUPT_AFTER.

Reset: stage=0, decoy=0, cnt=0, y=PAT.

Next-state rules from stage i, in priority order:
- hold=1: stay in stage i.
- go=0: stay in stage i.
- go=1, dir=0: move to stage (i-1) mod KEY_W. This move is ungated and never key-checked.
- go=1, dir=1, key[i]==CORRECT_KEY[i]: move to stage (i+1) mod KEY_W.
- go=1, dir=1, key[i]!=CORRECT_KEY[i]: enter decoy.
  - Decoy target is (i+1) mod KEY_W.
  - cnt increments unless already saturated.

Decoy state:
- x and key are ignored.
- Exactly one cycle later the machine moves to stage 0 unconditionally.
- The decoy cannot be re-entered directly from the decoy.

Output function:
- y <= rotl(PAT, s) ^ (corrupt_next ? CORRUPT_MASK : 0).
- s is the next stage, or the decoy target while in decoy.
- corrupt_next is evaluated from the post-update cnt.

Sticky rules:
- cnt and corrupt clear only on rst.
- A correct key never clears them.

## Timing
- One-cycle latency: y registered at edge N reflects the state entered at edge N.
- The decoy entry edge shows the target's pattern, identical to a correct advance. The following edge shows stage 0's pattern.
- Corruption takes effect on the same edge as the CORRUPT_AFTER-th decoy entry, and persists every cycle thereafter.
- rst has priority over everything, including decoy return and a simultaneous go.
  - On the next edge: y=PAT, stage=0, cnt=0, decoy=0.
  - This holds in any state, mid-decoy included.
- Wrap-around:
  - A forward advance from stage KEY_W-1 is gated by key[KEY_W-1] and lands in stage 0.
  - A reverse move from stage 0 lands in stage KEY_W-1.
- Counter saturation: decoy entries beyond CORRUPT_AFTER keep cnt=CORRUPT_AFTER, with no wrap.
- Stage rotation uses the stage index modulo OUT_W rotation with no truncation. OUT_W≥KEY_W guarantees distinct shifts.

## Test plan
All scenarios use default parameters.
- Reset: hold rst=1 for 2 cycles -> y=0x007; cnt=0.
- Correct-key forward ring: key=4'b1011, x=3'b011 for 4 cycles -> y=0x00E, 0x01C, 0x038, 0x007.
- Single wrong bit: key=4'b1111, advance to stage 2 (y=0x01C), then go forward -> y=0x038 (decoy mimic), then y=0x007 with x ignored (back to stage 0).
- Corruption threshold: repeat the wrong-bit scenario 5 times.
  - Fifth decoy entry gives y=0x038^0x1FF=0x1C7.
  - Return gives y=0x1F8.
  - Further correct advances give y=0x1F1, 0x1E3, persisting.
  - Then rst=1 -> y=0x007; a correct advance gives 0x00E.
- Hold and reverse: x=3'b111 -> y unchanged for 3 cycles. x=3'b001 from stage 0 with key=4'b0000 -> y=0x038 (ungated reverse, no decoy, cnt unchanged).
- Reset mid-decoy: rst=1 on the cycle the machine sits in decoy -> next y=0x007, cnt=0. A later single decoy entry does not corrupt.
